// File: rtl/free_list_pkg.sv
// Shared rename-path types: physical register index and free-list pointer widths.
package free_list_pkg;

  localparam int PREG_BITS     = 6;
  localparam int NUM_ARCH_REGS = 32;

  typedef logic [PREG_BITS-1:0] phys_reg_t;
  typedef logic [$clog2(2**PREG_BITS - NUM_ARCH_REGS):0] free_ptr_t;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical register indices: dispatch pops, commit pushes, flush refills.
// Optional FREE_LIST_BYPASS_EN forwards a same-cycle push to pd_out when the list is empty.
module free_list
  import free_list_pkg::*;
#(
  parameter int PHYS_REG_BITS = PREG_BITS,
  parameter int NUM_ARCH      = NUM_ARCH_REGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dequeue,
  output logic [PHYS_REG_BITS-1:0] pd_out,
  output logic                     pd_valid,
  input  logic                     enqueue,
  input  logic [PHYS_REG_BITS-1:0] pd_free,
  input  logic                     flush,
  output logic [PHYS_REG_BITS:0]   free_count
);

  localparam int NUM_PHYS = 2**PHYS_REG_BITS;
  localparam int NUM_FREE = NUM_PHYS - NUM_ARCH;
  localparam int IDX_W    = $clog2(NUM_FREE);
  localparam int PTR_W    = IDX_W + 1;

  if (NUM_FREE < 2 || (NUM_FREE & (NUM_FREE - 1)) != 0) begin : g_bad_size
    $error("free_list: NUM_PHYS - NUM_ARCH must be a power of two");
  end

  logic [PHYS_REG_BITS-1:0] entry [NUM_FREE];
  logic [PTR_W-1:0]         head, tail, head_next, tail_next, count;
  logic [IDX_W-1:0]         head_idx, tail_idx;
  logic                     empty, full, push_req, pop, push, bypass;

  always_comb begin
    head_idx = head[IDX_W-1:0];
    tail_idx = tail[IDX_W-1:0];
    empty    = (head == tail);
    full     = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    push_req = enqueue && (pd_free != '0);
`ifdef FREE_LIST_BYPASS_EN
    bypass   = empty && push_req && !flush;
`else
    bypass   = 1'b0;
`endif
    pop      = dequeue && !empty && !flush;
    // A bypassed push that dispatch consumes in the same cycle never enters storage.
    push     = push_req && (!full || pop) && !(bypass && dequeue);
    tail_next = tail + PTR_W'(push);
    head_next = flush ? {~tail_next[IDX_W], tail_next[IDX_W-1:0]}
                      : head + PTR_W'(pop);
    pd_out     = bypass ? pd_free : entry[head_idx];
    pd_valid   = !empty || bypass;
    count      = tail - head;
    free_count = (PHYS_REG_BITS+1)'(count);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= {1'b1, {IDX_W{1'b0}}};
      for (int i = 0; i < NUM_FREE; i++) begin
        entry[i] <= PHYS_REG_BITS'(NUM_ARCH + i);
      end
    end else begin
      if (push) begin
        entry[tail_idx] <= pd_free;
      end
      head <= head_next;
      tail <= tail_next;
      if (dequeue && !flush && !pd_valid) begin
        $warning("free_list: dequeue while empty ignored");
      end
      if (push_req && full && !pop) begin
        $warning("free_list: enqueue of %0d while full dropped", pd_free);
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list with hand-computed expectations (NUM_ARCH=32, NUM_FREE=32).
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst, dequeue, enqueue, flush;
  logic [5:0] pd_free, pd_out;
  logic       pd_valid;
  logic [6:0] free_count;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  free_list dut (
    .clk        (clk),
    .rst        (rst),
    .dequeue    (dequeue),
    .pd_out     (pd_out),
    .pd_valid   (pd_valid),
    .enqueue    (enqueue),
    .pd_free    (pd_free),
    .flush      (flush),
    .free_count (free_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic e, input logic [5:0] f,
                      input logic fl, input logic r);
    dequeue = d; enqueue = e; pd_free = f; flush = fl; rst = r;
    @(posedge clk);
    #1;
    dequeue = 1'b0; enqueue = 1'b0; pd_free = '0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic pops(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; dequeue = 1'b0; enqueue = 1'b0; flush = 1'b0; pd_free = '0;
    #2;
    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    chk("reset_count", 32'(free_count), 32);
    chk("reset_valid", 32'(pd_valid), 1);
    chk("reset_out", 32'(pd_out), 32);

    for (int i = 0; i < 32; i++) begin
      chk("drain_out", 32'(pd_out), 32'(32 + i));
      chk("drain_count", 32'(free_count), 32'(32 - i));
      step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    end
    chk("drained_valid", 32'(pd_valid), 0);
    chk("drained_count", 32'(free_count), 0);

    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("empty_deq_count", 32'(free_count), 0);
    chk("empty_deq_valid", 32'(pd_valid), 0);

    step(1'b0, 1'b1, 6'd40, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd41, 1'b0, 1'b0);
    chk("refill_count", 32'(free_count), 2);
    chk("refill_out", 32'(pd_out), 40);
    chk("refill_valid", 32'(pd_valid), 1);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("refill_next_out", 32'(pd_out), 41);
    chk("refill_next_count", 32'(free_count), 1);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("refill_empty_count", 32'(free_count), 0);

    // Push and pop together while empty.
    dequeue = 1'b1; enqueue = 1'b1; pd_free = 6'd40;
    #1;
`ifdef FREE_LIST_BYPASS_EN
    chk("bypass_out", 32'(pd_out), 40);
    chk("bypass_valid", 32'(pd_valid), 1);
`endif
    @(posedge clk);
    #1;
    dequeue = 1'b0; enqueue = 1'b0; pd_free = '0;
`ifdef FREE_LIST_BYPASS_EN
    chk("bypass_count", 32'(free_count), 0);
    chk("bypass_after_valid", 32'(pd_valid), 0);
`else
    chk("empty_both_count", 32'(free_count), 1);
    chk("empty_both_out", 32'(pd_out), 40);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("empty_both_drain", 32'(free_count), 0);
`endif

    step(1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
    chk("zero_on_empty_count", 32'(free_count), 0);
    chk("zero_on_empty_valid", 32'(pd_valid), 0);

    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
    chk("full_both_count", 32'(free_count), 32);
    chk("full_both_out", 32'(pd_out), 33);
    pops(31);
    chk("full_both_wrap_out", 32'(pd_out), 5);
    chk("full_both_wrap_count", 32'(free_count), 1);

    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 6'd9, 1'b0, 1'b0);
    chk("overflow_count", 32'(free_count), 32);
    chk("overflow_out", 32'(pd_out), 32);
    pops(31);
    chk("overflow_last_out", 32'(pd_out), 63);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("overflow_drained_count", 32'(free_count), 0);
    chk("overflow_drained_valid", 32'(pd_valid), 0);

    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
    chk("zero_free_count", 32'(free_count), 31);
    chk("zero_free_out", 32'(pd_out), 33);

    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    pops(10);
    chk("pre_flush_count", 32'(free_count), 22);
    chk("pre_flush_out", 32'(pd_out), 42);
    // The flush-cycle push fills slot 0, so the refilled ring starts at slot 1.
    step(1'b1, 1'b1, 6'd7, 1'b1, 1'b0);
    chk("flush_count", 32'(free_count), 32);
    chk("flush_out", 32'(pd_out), 33);
    chk("flush_valid", 32'(pd_valid), 1);
    pops(31);
    chk("flush_kept_out", 32'(pd_out), 7);
    chk("flush_kept_count", 32'(free_count), 1);

    step(1'b1, 1'b1, 6'd11, 1'b0, 1'b1);
    chk("midrst_out", 32'(pd_out), 32);
    chk("midrst_count", 32'(free_count), 32);
    pops(31);
    chk("midrst_last_out", 32'(pd_out), 63);
    chk("midrst_last_count", 32'(free_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
